serial_magnitude_compare_ctrl: RTL and testbench

//   Compares two wide unsigned operands using a single 4-bit magnitude comparator.
//   The block walks the operands one nibble per cycle, MSB nibble first, and stops
//   at the first nibble that differs. It sits in front of the 4-bit comparator

---
 rtl/serial_magnitude_compare_ctrl.sv | 83 ++++++++
 tb/tb_serial_magnitude_compare_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/serial_magnitude_compare_ctrl.sv
// serial_magnitude_compare_ctrl: walks two operands one nibble per cycle, MSB first, stopping at the first difference.
// Define COMPARE_SIGNED_EN for two's-complement ordering (MSB flipped at capture); default build is unsigned.
module serial_magnitude_compare_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [4*NIBBLES-1:0]             a_in,
  input  logic [4*NIBBLES-1:0]             b_in,
  output logic                             busy,
  output logic                             done,
  output logic                             less,
  output logic                             equal,
  output logic                             greater,
  output logic [$clog2(NIBBLES+1)-1:0]     nib_count
);
  localparam int W  = 4*NIBBLES;
  localparam int CW = $clog2(NIBBLES+1);
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t        r_state;
  logic [W-1:0]  r_a, r_b, w_a_cap, w_b_cap;
  logic [CW-1:0] r_idx;
  logic [3:0]    w_na, w_nb;
`ifdef COMPARE_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_a_cap = a_in ^ {1'b1, {(W-1){1'b0}}};
  assign w_b_cap = b_in ^ {1'b1, {(W-1){1'b0}}};
`else
  assign w_a_cap = a_in;
  assign w_b_cap = b_in;
`endif
  assign w_na = r_a[W-1 -: 4];
  assign w_nb = r_b[W-1 -: 4];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      less      <= 1'b0;
      equal     <= 1'b0;
      greater   <= 1'b0;
      nib_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= w_a_cap;
          r_b     <= w_b_cap;
          r_idx   <= CW'(NIBBLES-1);
          busy    <= 1'b1;
          r_state <= CMP;
        end
        CMP: if (w_na != w_nb) begin
          less      <= w_na < w_nb;
          greater   <= w_na > w_nb;
          equal     <= 1'b0;
          nib_count <= CW'(NIBBLES) - r_idx;
          done      <= 1'b1;
          r_state   <= DONE;
        end else if (r_idx == '0) begin
          less      <= 1'b0;
          greater   <= 1'b0;
          equal     <= 1'b1;
          nib_count <= CW'(NIBBLES);
          done      <= 1'b1;
          r_state   <= DONE;
        end else begin
          r_a   <= r_a << 4;
          r_b   <= r_b << 4;
          r_idx <= r_idx - 1'b1;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// tb_serial_magnitude_compare_ctrl: directed + random scoreboard bench for serial_magnitude_compare_ctrl
module tb_serial_magnitude_compare_ctrl;
  localparam int NIBBLES = 4;
  localparam int W = 4*NIBBLES;
  typedef struct {logic l; logic e; logic g; int k;} exp_t;
  logic clk = 0, rst = 0, start = 0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic busy, done, less, equal, greater;
  logic [2:0] nib_count;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic p_l = 0, p_e = 0, p_g = 0;
  always #5 clk = ~clk;
  serial_magnitude_compare_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .less(less), .equal(equal), .greater(greater),
    .nib_count(nib_count));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
`ifdef COMPARE_SIGNED_EN
    e.l = $signed(a) < $signed(b);
    e.g = $signed(a) > $signed(b);
`else
    e.l = a < b;
    e.g = a > b;
`endif
    e.e = a == b;
    e.k = NIBBLES;
    for (int i = 0; i < NIBBLES; i++)
      if (a[4*i +: 4] != b[4*i +: 4]) e.k = NIBBLES - i;
    return e;
  endfunction
  // hold: number of extra edges start stays high (with other operands) while busy
  task automatic run_cmp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int cnt;
    q.push_back(model(a, b));
    @(negedge clk);
    a_in = a; b_in = b; start = 1;
    @(posedge clk); #1;
    if (hold == 0) start = 0;
    else begin a_in = '0; b_in = W'(5); end
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt >= hold) start = 0;
      if (done) break;
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_hold"}, {less, equal, greater}, {p_l, p_e, p_g});
    end
    e = q.pop_front();
    chk({tag, "_latency"}, cnt, e.k);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_res"}, {less, equal, greater}, {e.l, e.e, e.g});
    chk({tag, "_nib"}, nib_count, e.k);
    p_l = e.l; p_e = e.e; p_g = e.g;
    @(posedge clk); #1;
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_res_held"}, {less, equal, greater}, {e.l, e.e, e.g});
  endtask
  initial begin
    rst = 1;
    #12 rst = 0;
    @(posedge clk); #1;
    chk("reset_state", {busy, done, less, equal, greater, nib_count}, 0);
    run_cmp("eq_1234", 16'h1234, 16'h1234, 0);
    run_cmp("msb_8000", 16'h8000, 16'h7FFF, 0);
    run_cmp("lt_12a4", 16'h12A4, 16'h12B0, 0);
    run_cmp("ignore_start", 16'h0001, 16'h0000, 2);
    run_cmp("b2b_lt", 16'h0000, 16'h0005, 0);
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h1234; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    #1;
    chk("abort_out", {busy, done, less, equal, greater, nib_count}, 0);
    p_l = 0; p_e = 0; p_g = 0;
    @(negedge clk) rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {busy, done}, 0);
    end
    run_cmp("after_abort", 16'hFFFF, 16'h0000, 0);
    for (int i = 0; i < 8; i++)
      run_cmp("rand", W'($urandom), W'($urandom), 0);
    run_cmp("rand_near", 16'hA5C3, 16'hA5C3 ^ W'(1 << $urandom_range(0, 15)), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
